// File: rtl/freq_meter_pkg.sv
// rtl/freq_meter_pkg.sv - shared state encoding and constants for freq_meter_gate
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GATE     = 2'd1,
    WAIT_RES = 2'd2
  } state_e;

  localparam int MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/freq_meter_gate_sync.sv
// rtl/freq_meter_gate_sync.sv - multi-flop single-bit synchroniser with async clear
module sync_bit
  import freq_meter_pkg::*;
#(
  parameter int SYNC_STAGES = 3
) (
  input  logic clk,
  input  logic clr_n_i,
  input  logic d_i,
  output logic q_o
);

  // Depths below the safe minimum are raised rather than rejected.
  localparam int STAGES = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge clr_n_i) begin
    if (!clr_n_i) sync_q <= '0;
    else          sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/freq_meter_gate.sv
// rtl/freq_meter_gate.sv - gated frequency meter: clk-domain gate, clk_meas-domain counter
module freq_meter_gate
  import freq_meter_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int RES_W       = 32,
  parameter int SYNC_STAGES = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clk_meas,
  input  logic             start,
  input  logic             mode,
  input  logic [CNT_W-1:0] threshold,
  output logic             busy,
  output logic             gate,
  output logic [RES_W-1:0] result,
  output logic             result_valid,
  output logic             result_sat,
  output logic             cfg_err
);

  logic rst_clk_n, rst_meas_n, gate_s, tgl_s;

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_rst_clk  (.clk(clk),      .clr_n_i(resetn),    .d_i(1'b1),     .q_o(rst_clk_n));
  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_rst_meas (.clk(clk_meas), .clr_n_i(resetn),    .d_i(1'b1),     .q_o(rst_meas_n));
  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_gate     (.clk(clk_meas), .clr_n_i(rst_meas_n), .d_i(gate),     .q_o(gate_s));

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, thr_q, thr_d;
  logic [RES_W-1:0] result_d;
  logic             result_sat_d, result_valid_d, cfg_err_d, gate_d, busy_d;
  logic             cfg_pend_q, cfg_pend_d, tgl_prev_q;
  logic [RES_W-1:0] meas_cnt_q, meas_cnt_d, hold_cnt_q, hold_cnt_d;
  logic             meas_sat_q, meas_sat_d, hold_sat_q, hold_sat_d;
  logic             res_tgl_q, res_tgl_d, gate_prev_q;

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_tgl (.clk(clk), .clr_n_i(rst_clk_n), .d_i(res_tgl_q), .q_o(tgl_s));

  // Hold registers are static once the toggle edge has crossed back.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    thr_d          = thr_q;
    result_d       = result;
    result_sat_d   = result_sat;
    result_valid_d = 1'b0;
    cfg_err_d      = cfg_pend_q;
    cfg_pend_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (threshold != '0) begin
            thr_d   = threshold;
            cnt_d   = CNT_W'(1);
            state_d = GATE;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      GATE: begin
        if (cnt_q == thr_q) state_d = WAIT_RES;
        else                cnt_d   = cnt_q + CNT_W'(1);
      end
      WAIT_RES: begin
        if (tgl_s ^ tgl_prev_q) begin
          result_d       = hold_cnt_q;
          result_sat_d   = hold_sat_q;
          result_valid_d = 1'b1;
          state_d        = IDLE;
          if (mode) begin
            thr_d = threshold;
            if (threshold != '0) begin
              cnt_d   = CNT_W'(1);
              state_d = GATE;
            end else begin
              // Deferred so it never coincides with result_valid.
              cfg_pend_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    gate_d = (state_d == GATE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_clk_n) begin
    if (!rst_clk_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      thr_q        <= '0;
      result       <= '0;
      result_sat   <= 1'b0;
      result_valid <= 1'b0;
      cfg_err      <= 1'b0;
      cfg_pend_q   <= 1'b0;
      gate         <= 1'b0;
      busy         <= 1'b0;
      tgl_prev_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      thr_q        <= thr_d;
      result       <= result_d;
      result_sat   <= result_sat_d;
      result_valid <= result_valid_d;
      cfg_err      <= cfg_err_d;
      cfg_pend_q   <= cfg_pend_d;
      gate         <= gate_d;
      busy         <= busy_d;
      tgl_prev_q   <= tgl_s;
    end
  end

  always_comb begin
    meas_cnt_d = meas_cnt_q;
    meas_sat_d = meas_sat_q;
    hold_cnt_d = hold_cnt_q;
    hold_sat_d = hold_sat_q;
    res_tgl_d  = res_tgl_q;
    if (gate_s && !gate_prev_q) begin
      meas_cnt_d = RES_W'(1);
      meas_sat_d = 1'b0;
    end else if (gate_s) begin
      if (meas_cnt_q == '1) meas_sat_d = 1'b1;
      else                  meas_cnt_d = meas_cnt_q + RES_W'(1);
    end else if (gate_prev_q) begin
      hold_cnt_d = meas_cnt_q;
      hold_sat_d = meas_sat_q;
      res_tgl_d  = ~res_tgl_q;
    end
  end

  always_ff @(posedge clk_meas or negedge rst_meas_n) begin
    if (!rst_meas_n) begin
      meas_cnt_q  <= '0;
      meas_sat_q  <= 1'b0;
      hold_cnt_q  <= '0;
      hold_sat_q  <= 1'b0;
      res_tgl_q   <= 1'b0;
      gate_prev_q <= 1'b0;
    end else begin
      meas_cnt_q  <= meas_cnt_d;
      meas_sat_q  <= meas_sat_d;
      hold_cnt_q  <= hold_cnt_d;
      hold_sat_q  <= hold_sat_d;
      res_tgl_q   <= res_tgl_d;
      gate_prev_q <= gate_s;
    end
  end

endmodule

// File: tb/tb_freq_meter_gate.sv
// tb/tb_freq_meter_gate.sv - randomized self-checking bench for freq_meter_gate
`timescale 1ns/10ps
module tb_freq_meter_gate;

  logic        clk = 1'b0, clk_meas = 1'b0, clk_eq = 1'b0;
  logic        resetn = 1'b1, start = 1'b0, mode = 1'b0, start8 = 1'b0;
  logic [31:0] threshold = '0, threshold8 = '0;
  logic        busy, gate, result_valid, result_sat, cfg_err;
  logic [31:0] result;
  logic        busy8, gate8, result_valid8, result_sat8, cfg_err8;
  logic [7:0]  result8;
  real         meas_half = 10.0;

  freq_meter_gate #(.CNT_W(32), .RES_W(32), .SYNC_STAGES(3)) u_dut (
    .clk(clk), .resetn(resetn), .clk_meas(clk_meas), .start(start), .mode(mode),
    .threshold(threshold), .busy(busy), .gate(gate), .result(result),
    .result_valid(result_valid), .result_sat(result_sat), .cfg_err(cfg_err));

  freq_meter_gate #(.CNT_W(32), .RES_W(8), .SYNC_STAGES(2)) u_dut8 (
    .clk(clk), .resetn(resetn), .clk_meas(clk_eq), .start(start8), .mode(1'b0),
    .threshold(threshold8), .busy(busy8), .gate(gate8), .result(result8),
    .result_valid(result_valid8), .result_sat(result_sat8), .cfg_err(cfg_err8));

  always #5 clk = ~clk;
  initial begin #2.3; forever #(meas_half) clk_meas = ~clk_meas; end
  initial begin #3.1; forever #5 clk_eq = ~clk_eq; end

  int total = 0, bad = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint lo, input longint hi);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
    end
  endtask

  // Model: each expected gate carries its length and the clk_meas period used.
  typedef struct { int thr; int tm; } exp_t;
  exp_t   gate_exp_q[$], res_exp_q[$];
  int     run = 0, last_len = 0, valid_seen = 0, cfg_seen = 0, cfg_exp = 0;
  longint last_res = 0, prev_result = 0;

  always @(negedge clk) begin
    exp_t   e;
    longint lo, hi, maxv;
    if (!resetn) begin
      run = 0;
      gate_exp_q.delete();
      res_exp_q.delete();
      prev_result = 0;
    end else begin
      if (gate) run++;
      else if (run > 0) begin
        last_len = run;
        if (gate_exp_q.size() == 0) check(1'b0, "unexpected_gate", run, 0, 0);
        else begin
          e = gate_exp_q.pop_front();
          check(run == e.thr, "gate_len", run, e.thr, e.thr);
          res_exp_q.push_back(e);
        end
        run = 0;
      end
      check(!gate || busy, "gate_implies_busy", busy, 1, 1);
      check(!(result_valid && cfg_err), "valid_cfg_overlap", cfg_err, 0, 0);
      if (result_valid) begin
        valid_seen++;
        last_res = result;
        if (res_exp_q.size() == 0) check(1'b0, "unexpected_result", result, 0, 0);
        else begin
          e    = res_exp_q.pop_front();
          maxv = (64'd1 << 32) - 1;
          lo   = e.thr * 10 / e.tm - 1;
          hi   = (e.thr * 10 + e.tm - 1) / e.tm + 1;
          if (lo < 0) lo = 0;
          check(result >= lo && result <= hi, "result_range", result, lo, hi);
          check(result_sat == (lo > maxv), "result_sat", result_sat, lo > maxv, lo > maxv);
        end
      end else begin
        check(result == prev_result, "result_held", result, prev_result, prev_result);
      end
      prev_result = result;
      if (cfg_err) cfg_seen++;
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 5000) begin @(negedge clk); n++; end
    if (busy) check(1'b0, "idle_timeout", n, 0, 5000);
  endtask

  task automatic wait_valids(input int target);
    int n = 0;
    while (valid_seen < target && n < 10000) begin @(negedge clk); n++; end
    if (valid_seen < target) check(1'b0, "valid_timeout", valid_seen, target, target);
  endtask

  task automatic wait_one_gate();
    int n = 0;
    while (!gate && n < 5000) begin @(negedge clk); n++; end
    while (gate && n < 5000) begin @(negedge clk); n++; end
    if (n >= 5000) check(1'b0, "gate_timeout", n, 0, 5000);
  endtask

  task automatic pulse_start(input int thr, input bit md);
    @(negedge clk);
    threshold = thr;
    mode      = md;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic expect_gates(input int thr, input int tm, input int n);
    exp_t e;
    e.thr = thr;
    e.tm  = tm;
    for (int i = 0; i < n; i++) gate_exp_q.push_back(e);
  endtask

  task automatic one_shot(input int thr, input int tm);
    meas_half = tm / 2.0;
    if (thr != 0) expect_gates(thr, tm, 1);
    else cfg_exp++;
    pulse_start(thr, 1'b0);
    wait_idle();
    repeat (3) @(negedge clk);
  endtask

  task automatic continuous(input int thr, input int tm, input int n);
    int base = valid_seen;
    meas_half = tm / 2.0;
    expect_gates(thr, tm, n);
    pulse_start(thr, 1'b1);
    wait_valids(base + n - 1);
    wait_one_gate();
    mode = 1'b0;
    wait_idle();
    repeat (40) @(negedge clk);
    check(valid_seen == base + n, "cont_valid_count", valid_seen - base, n, n);
  endtask

  initial begin
    int     cfg0, n, tm, op, thr, nv;
    longint r0;
    #1 resetn = 1'b0;
    #1;
    check({busy, gate, result, result_valid, result_sat, cfg_err} == '0, "reset_outputs", result, 0, 0);
    check({busy8, gate8, result8, result_valid8, result_sat8, cfg_err8} == '0, "reset_outputs8", result8, 0, 0);
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);

    one_shot(100, 20);
    check(last_len == 100, "lit_gate_100", last_len, 100, 100);
    check(last_res >= 49 && last_res <= 51, "lit_res_50", last_res, 49, 51);
    check(busy == 1'b0, "lit_busy_clear", busy, 0, 0);

    one_shot(1, 10);
    check(last_res <= 2, "lit_res_thr1", last_res, 0, 2);

    cfg0 = cfg_seen;
    r0   = result;
    cfg_exp++;
    pulse_start(0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check(!busy && !gate, "cfg_no_busy", {busy, gate}, 0, 0);
      @(negedge clk);
    end
    check(cfg_seen == cfg0 + 1, "lit_cfg_once", cfg_seen - cfg0, 1, 1);
    check(result == r0, "cfg_result_kept", result, r0, r0);

    continuous(20, 40, 3);
    check(last_res >= 4 && last_res <= 6, "lit_res_cont", last_res, 4, 6);

    meas_half = 10.0;
    expect_gates(30, 20, 1);
    cfg_exp++;
    nv = valid_seen;
    pulse_start(30, 1'b1);
    wait_one_gate();
    threshold = 0;
    n = 0;
    while (!result_valid && n < 5000) begin @(negedge clk); n++; end
    check(result_valid, "rearm0_valid", result_valid, 1, 1);
    @(negedge clk);
    check(cfg_err && !result_valid, "rearm0_cfg_next", cfg_err, 1, 1);
    check(!busy, "rearm0_idle", busy, 0, 0);
    mode = 1'b0;
    repeat (5) @(negedge clk);

    threshold8 = 1000;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    n = 0;
    while (!result_valid8 && n < 3000) begin @(negedge clk); n++; end
    check(result8 == 8'd255, "lit_sat_result", result8, 255, 255);
    check(result_sat8 == 1'b1, "lit_sat_flag", result_sat8, 1, 1);

    meas_half = 10.0;
    expect_gates(100, 20, 1);
    pulse_start(100, 1'b0);
    n = 0;
    while (!gate && n < 100) begin @(negedge clk); n++; end
    repeat (36) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check({busy, gate, result, result_valid, result_sat, cfg_err} == '0, "midgate_reset", result, 0, 0);
    repeat (5) @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    one_shot(100, 20);
    check(last_res >= 49 && last_res <= 51, "lit_after_reset", last_res, 49, 51);

    for (int it = 0; it < 24; it++) begin
      tm  = 10 * $urandom_range(1, 4);
      op  = $urandom_range(0, 3);
      thr = $urandom_range(tm / 5, 80);
      if (op == 0)      one_shot(0, tm);
      else if (op == 3) continuous(thr, tm, $urandom_range(2, 3));
      else              one_shot(thr, tm);
    end

    repeat (20) @(negedge clk);
    check(gate_exp_q.size() == 0, "gates_all_seen", gate_exp_q.size(), 0, 0);
    check(res_exp_q.size() == 0, "results_all_seen", res_exp_q.size(), 0, 0);
    check(cfg_seen == cfg_exp, "cfg_count", cfg_seen, cfg_exp, cfg_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900us;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
